// File: rtl/mem_ctrl_if.sv
// Request/response and byte-wide RAM bus signals between the pipeline stages and mem_ctrl.
// The controller takes the slave view; requesters and the RAM model take the master view.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        cancel;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_width;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  modport slave (
    input  if_req, if_addr, cancel, mem_re, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    output if_done, if_rdata, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, cancel, mem_re, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    input  if_done, if_rdata, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Fixed-priority fetch/load/store arbiter that serialises each request into byte cycles
// on a single-port byte-wide RAM and assembles little-endian read data.
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  // state  | meaning
  // IDLE   | waiting for a request; blocked while a done pulse is high
  // IF_RD  | fetch word read, abortable by cancel
  // MEM_RD | load of 1/2/4 bytes
  // MEM_WR | store of 1/2/4 bytes
  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, n;
  logic [31:0] base, wdata, rbuf, rbuf_cap;
  logic        if_done, mem_done;
  logic [31:0] if_rdata, mem_rdata;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic        fetch_abort;

  function automatic logic [2:0] width_n(input logic [1:0] w);
    case (w)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign fetch_abort = (state == IF_RD) && bus.cancel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_a     = 32'd0;
    ram_dout  = 8'd0;
    ram_wr    = 1'b0;
    rbuf_cap  = rbuf;
    case (state)
      IDLE: begin
        if (!(if_done || mem_done)) begin
          if (bus.mem_we)                      state_nxt = MEM_WR;
          else if (bus.mem_re)                 state_nxt = MEM_RD;
          else if (bus.if_req && !bus.cancel)  state_nxt = IF_RD;
        end
      end
      IF_RD, MEM_RD: begin
        if (cnt < n) ram_a = base + {29'd0, cnt};
        // ram_din answers the address driven in the previous cycle
        for (int k = 0; k < 4; k++)
          if (cnt == 3'(k + 1)) rbuf_cap[8*k +: 8] = bus.ram_din;
        if (fetch_abort || cnt == n) state_nxt = IDLE;
      end
      MEM_WR: begin
        if (cnt < n) begin
          ram_wr = 1'b1;
          ram_a  = base + {29'd0, cnt};
          for (int k = 0; k < 4; k++)
            if (cnt == 3'(k)) ram_dout = wdata[8*k +: 8];
        end
        if (cnt == 3'(n - 3'd1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      n         <= 3'd0;
      base      <= 32'd0;
      wdata     <= 32'd0;
      rbuf      <= 32'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt != IDLE) begin
            cnt  <= 3'd0;
            rbuf <= 32'd0;
            if (state_nxt == IF_RD) begin
              base <= bus.if_addr;
              n    <= 3'd4;
            end else begin
              base  <= bus.mem_addr;
              n     <= width_n(bus.mem_width);
              wdata <= bus.mem_wdata;
            end
          end
        end
        IF_RD, MEM_RD: begin
          cnt  <= cnt + 3'd1;
          rbuf <= rbuf_cap;
          if (cnt == n && !fetch_abort) begin
            if (state == IF_RD) begin
              if_done  <= 1'b1;
              if_rdata <= rbuf_cap;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= rbuf_cap;
            end
          end
        end
        MEM_WR: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'(n - 3'd1)) mem_done <= 1'b1;
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

  assign bus.if_done   = if_done;
  assign bus.if_rdata  = if_rdata;
  assign bus.mem_done  = mem_done;
  assign bus.mem_rdata = mem_rdata;
  assign bus.ram_a     = ram_a;
  assign bus.ram_dout  = ram_dout;
  assign bus.ram_wr    = ram_wr;

endmodule
